// File: rtl/mist_io_pkg.sv
// Shared MiST user_io command codes, host FSM state type and payload limit.
// Pure declarations: no latency, no flow control.
package mist_io_pkg;

  localparam logic [7:0] CMD_BUT_SW   = 8'h01;
  localparam logic [7:0] CMD_JOY0     = 8'h02;
  localparam logic [7:0] CMD_JOY1     = 8'h03;
  localparam logic [7:0] CMD_PS2_KBD  = 8'h05;
  localparam logic [7:0] CMD_GET_CONF = 8'h14;
  localparam logic [7:0] CMD_STATUS32 = 8'h1E;

  localparam int MAX_PAYLOAD = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_TAIL,
    S_GAP
  } spi_host_state_t;

  function automatic logic [2:0] clamp_len(input logic [2:0] len);
    return (int'(len) > MAX_PAYLOAD) ? 3'(MAX_PAYLOAD) : len;
  endfunction

endpackage

// File: rtl/mist_spi_host_sck_gen.sv
// SCK half-period timer: tick every CLK_DIV cycles while run, SCK toggles on tick while shift.
// Counter and SCK are held cleared when idle; no backpressure.
module spi_sck_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic shift,
  output logic tick,
  output logic rise,
  output logic fall,
  output logic sck
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;
  logic          sck_q;

  assign tick = run && (cnt == CNT_LAST);
  assign rise = shift && tick && !sck_q;
  assign fall = shift && tick && sck_q;
  assign sck  = sck_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      sck_q <= 1'b0;
    end else begin
      if (!run || tick) cnt <= '0;
      else              cnt <= cnt + 1'b1;

      if (!shift)    sck_q <= 1'b0;
      else if (tick) sck_q <= ~sck_q;
    end
  end

endmodule

// File: rtl/mist_spi_host.sv
// MiST user_io SPI host: one command byte plus 0-4 payload bytes per request, done after CLK_DIV*(2+16*(1+len)) cycles.
// Requests only taken in IDLE (req_ready), never queued; MIST_SPI_HOST_RX_EN builds MISO byte capture.
module mist_spi_host
  import mist_io_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int GAP_HP  = 2
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [7:0]  req_cmd,
  input  logic [2:0]  req_len,
  input  logic [31:0] req_data,
  output logic        done,
  output logic        rx_valid,
  output logic [7:0]  rx_byte,
  output logic [2:0]  rx_index,
  output logic        SPI_SCK,
  output logic        SPI_SS_IO,
  output logic        SPI_MOSI,
  input  logic        SPI_MISO
);

  localparam int GW = (GAP_HP > 1) ? $clog2(GAP_HP) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_HP - 1);

  spi_host_state_t state, state_nxt;

  logic          tick, rise, fall, sck;
  logic          accept, last_fall, frame_end, ss_nxt;
  logic [39:0]   tx_sr;
  logic [5:0]    total_rises, rise_cnt;
  logic [GW-1:0] gap_cnt;
  logic          ss_q, mosi_q, done_q;

  spi_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck (
    .clk   (clk_sys),
    .rst   (reset),
    .run   (state != S_IDLE),
    .shift (state == S_SHIFT),
    .tick  (tick),
    .rise  (rise),
    .fall  (fall),
    .sck   (sck)
  );

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept)    state_nxt = S_SETUP;
      S_SETUP: if (tick)      state_nxt = S_SHIFT;
      S_SHIFT: if (last_fall) state_nxt = S_TAIL;
      S_TAIL:  if (tick)      state_nxt = (GAP_HP == 0) ? S_IDLE : S_GAP;
      S_GAP:   if (tick && gap_cnt == GAP_LAST) state_nxt = S_IDLE;
      default:                state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state == S_IDLE);
    accept    = req_valid && (state == S_IDLE);
    last_fall = fall && (rise_cnt == total_rises);
    frame_end = (state == S_TAIL) && tick;
    ss_nxt    = !(state_nxt inside {S_SETUP, S_SHIFT, S_TAIL});
  end

  // Payload is packed behind the command so the whole frame shifts out of bit 39.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      tx_sr       <= '0;
      total_rises <= '0;
      rise_cnt    <= '0;
      gap_cnt     <= '0;
      ss_q        <= 1'b1;
      mosi_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= frame_end;
      ss_q   <= ss_nxt;

      if (accept) begin
        tx_sr       <= {req_cmd, req_data[7:0], req_data[15:8], req_data[23:16], req_data[31:24]};
        total_rises <= {clamp_len(req_len), 3'b000} + 6'd8;
        rise_cnt    <= '0;
        mosi_q      <= req_cmd[7];
      end

      if (rise) rise_cnt <= rise_cnt + 1'b1;

      if (fall) begin
        if (last_fall) begin
          mosi_q <= 1'b0;
        end else begin
          mosi_q <= tx_sr[38];
          tx_sr  <= {tx_sr[38:0], 1'b0};
        end
      end

      if (state != S_GAP) gap_cnt <= '0;
      else if (tick)      gap_cnt <= gap_cnt + 1'b1;
    end
  end

  assign SPI_SCK   = sck;
  assign SPI_SS_IO = ss_q;
  assign SPI_MOSI  = mosi_q;
  assign done      = done_q;

`ifdef MIST_SPI_HOST_RX_EN
  logic [7:0] rx_sr;
  logic       byte_end;
  logic       rx_valid_q;
  logic [7:0] rx_byte_q;
  logic [2:0] rx_index_q;

  // byte_end marks the 8th rise of a byte; the capture is published one cycle later.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      rx_sr      <= '0;
      byte_end   <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_byte_q  <= '0;
      rx_index_q <= '0;
    end else begin
      byte_end   <= rise && (rise_cnt[2:0] == 3'd7);
      rx_valid_q <= byte_end;
      if (rise) rx_sr <= {rx_sr[6:0], SPI_MISO};
      if (byte_end) begin
        rx_byte_q  <= rx_sr;
        rx_index_q <= rise_cnt[5:3] - 3'd1;
      end
    end
  end

  assign rx_valid = rx_valid_q;
  assign rx_byte  = rx_byte_q;
  assign rx_index = rx_index_q;
`else
  logic unused_miso;
  assign unused_miso = SPI_MISO;
  assign rx_valid    = 1'b0;
  assign rx_byte     = 8'h00;
  assign rx_index    = 3'd0;
`endif

endmodule

// File: tb/tb_mist_spi_host.sv
// Bench for mist_spi_host: randomized frames against a frame/latency model plus an SPI slave monitor.
// Capture checks run only when MIST_SPI_HOST_RX_EN is defined.
module tb_mist_spi_host;
  import mist_io_pkg::*;

  localparam int DIV = 4;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [7:0]  req_cmd = 8'h00;
  logic [2:0]  req_len = 3'd0;
  logic [31:0] req_data = 32'h0;
  logic        done, rx_valid;
  logic [7:0]  rx_byte;
  logic [2:0]  rx_index;
  logic        SPI_SCK, SPI_SS_IO, SPI_MOSI;
  logic        SPI_MISO = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  mist_spi_host #(.CLK_DIV(DIV), .GAP_HP(2)) dut (
    .clk_sys(clk_sys), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_cmd(req_cmd), .req_len(req_len), .req_data(req_data),
    .done(done), .rx_valid(rx_valid), .rx_byte(rx_byte), .rx_index(rx_index),
    .SPI_SCK(SPI_SCK), .SPI_SS_IO(SPI_SS_IO), .SPI_MOSI(SPI_MOSI), .SPI_MISO(SPI_MISO)
  );

  always #5 clk_sys = ~clk_sys;

  int cyc = 0;
  always @(posedge clk_sys) cyc <= cyc + 1;

  // Slave-side monitor: samples on the falling clk_sys edge, away from DUT updates.
  bit          prev_sck = 1'b0, prev_ss = 1'b1, seen_frame = 1'b0;
  bit          mosi_q[$];
  logic [7:0]  rxb_q[$];
  logic [2:0]  rxi_q[$];
  logic [39:0] miso_vec = '0;
  int miso_idx = 0, done_cnt = 0, rx_cnt = 0, accept_cnt = 0;
  int mosi_idle_err = 0, ss_done_err = 0, last_done_cyc = 0;
  int ss_high_run = 0, min_gap = 1000;

  always @(negedge clk_sys) begin
    if (prev_ss && !SPI_SS_IO) begin
      mosi_q.delete();
      miso_idx = 0;
      SPI_MISO = miso_vec[39];
      if (seen_frame && ss_high_run < min_gap) min_gap = ss_high_run;
      seen_frame = 1'b1;
    end
    if (SPI_SS_IO) ss_high_run++;
    else           ss_high_run = 0;
    if (!SPI_SS_IO && SPI_SCK && !prev_sck) mosi_q.push_back(SPI_MOSI);
    if (!SPI_SS_IO && !SPI_SCK && prev_sck) begin
      miso_idx++;
      SPI_MISO = (miso_idx < 40) ? miso_vec[39 - miso_idx] : 1'b0;
    end
    if (SPI_SS_IO && SPI_MOSI) mosi_idle_err++;
    if (done) begin
      done_cnt++;
      last_done_cyc = cyc;
      if (!SPI_SS_IO) ss_done_err++;
    end
    if (rx_valid) begin
      rx_cnt++;
      rxb_q.push_back(rx_byte);
      rxi_q.push_back(rx_index);
    end
    if (req_valid && req_ready) accept_cnt++;
    prev_sck = SPI_SCK;
    prev_ss  = SPI_SS_IO;
  end

  // Expected MOSI frame: command byte then min(len,4) payload bytes, byte 0 first, left-aligned.
  function automatic logic [39:0] exp_frame(logic [7:0] c, logic [2:0] l, logic [31:0] d);
    int n;
    logic [39:0] v;
    n = (l > 3'd4) ? 4 : int'(l);
    v = {c, 32'h0};
    for (int k = 0; k < n; k++) v[31 - 8*k -: 8] = d[8*k +: 8];
    return v;
  endfunction

  task automatic do_frame(input logic [7:0] c, input logic [2:0] l, input logic [31:0] d,
                          output int lat, output int rises, output logic [39:0] got,
                          output int ndone, output bit timed_out);
    int w, d0, acc;
    lat = 0; rises = 0; got = '0; ndone = 0; timed_out = 1'b0;
    @(posedge clk_sys); #2;
    w = 0;
    while (!req_ready && w < 2000) begin @(posedge clk_sys); #2; w++; end
    if (!req_ready) begin timed_out = 1'b1; return; end
    req_valid = 1'b1; req_cmd = c; req_len = l; req_data = d;
    @(posedge clk_sys); #1;
    acc = cyc; d0 = done_cnt;
    #1;
    req_valid = 1'b0; req_cmd = 8'($urandom); req_len = 3'($urandom); req_data = $urandom;
    w = 0;
    while (done_cnt == d0 && w < 2000) begin @(posedge clk_sys); #2; w++; end
    if (done_cnt == d0) begin timed_out = 1'b1; return; end
    lat = last_done_cyc - acc;
    rises = mosi_q.size();
    for (int i = 0; i < rises && i < 40; i++) got[39 - i] = mosi_q[i];
    w = 0;
    while (!req_ready && w < 200) begin @(posedge clk_sys); #2; w++; end
    repeat (2) @(posedge clk_sys);
    #2;
    ndone = done_cnt - d0;
  endtask

  task automatic test_reset();
    repeat (5) @(posedge clk_sys);
    #2;
    req_cmd = 8'($urandom); req_len = 3'($urandom); req_data = $urandom;
    reset = 1'b1;
    #1;
    n_cmp++; if (SPI_SS_IO !== 1'b1) begin n_bad++; $display("FAIL reset_ss: got %b want 1", SPI_SS_IO); end
    n_cmp++; if (SPI_SCK !== 1'b0) begin n_bad++; $display("FAIL reset_sck: got %b want 0", SPI_SCK); end
    n_cmp++; if (SPI_MOSI !== 1'b0) begin n_bad++; $display("FAIL reset_mosi: got %b want 0", SPI_MOSI); end
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", req_ready); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
    @(posedge clk_sys); #2;
    n_cmp++; if ({rx_valid, rx_byte, rx_index} !== 12'h0) begin
      n_bad++; $display("FAIL reset_rx: got %b/%h/%0d want 0/00/0", rx_valid, rx_byte, rx_index);
    end
    reset = 1'b0;
    repeat (3) @(posedge clk_sys);
    #2;
    n_cmp++; if (req_ready !== 1'b1 || SPI_SS_IO !== 1'b1) begin
      n_bad++; $display("FAIL post_reset_idle: ready=%b ss=%b want 1/1", req_ready, SPI_SS_IO);
    end
  endtask

  task automatic test_status32();
    int lat, rises, nd;
    logic [39:0] got;
    logic [31:0] status;
    bit to;
    do_frame(CMD_STATUS32, 3'd4, 32'h00000045, lat, rises, got, nd, to);
    n_cmp++; if (to) begin n_bad++; $display("FAIL status_timeout: got timeout want done"); end
    n_cmp++; if (rises !== 40) begin n_bad++; $display("FAIL status_rises: got %0d want 40", rises); end
    n_cmp++; if (lat !== 328) begin n_bad++; $display("FAIL status_latency: got %0d want 328", lat); end
    n_cmp++; if (got[39:32] !== CMD_STATUS32) begin n_bad++; $display("FAIL status_cmd: got %h want 1e", got[39:32]); end
    status = {got[7:0], got[15:8], got[23:16], got[31:24]};
    n_cmp++; if (status !== 32'h00000045) begin n_bad++; $display("FAIL status_value: got %h want 00000045", status); end
    n_cmp++; if (nd !== 1) begin n_bad++; $display("FAIL status_done_count: got %0d want 1", nd); end
  endtask

  task automatic test_joystick_clamp();
    int lat, rises, nd;
    logic [39:0] got;
    logic [31:0] joy;
    bit to;
    do_frame(CMD_JOY0, 3'd4, 32'h00000011, lat, rises, got, nd, to);
    joy = {got[7:0], got[15:8], got[23:16], got[31:24]};
    n_cmp++; if (to || got[39:32] !== CMD_JOY0 || joy !== 32'h11) begin
      n_bad++; $display("FAIL joy0_value: got cmd %h joy %h want 02/00000011", got[39:32], joy);
    end
    do_frame(CMD_JOY0, 3'd7, 32'h00000011, lat, rises, got, nd, to);
    n_cmp++; if (rises !== 40) begin n_bad++; $display("FAIL clamp_rises: got %0d want 40", rises); end
    n_cmp++; if (lat !== 328) begin n_bad++; $display("FAIL clamp_latency: got %0d want 328", lat); end
    n_cmp++; if (got !== exp_frame(CMD_JOY0, 3'd7, 32'h11)) begin
      n_bad++; $display("FAIL clamp_frame: got %h want %h", got, exp_frame(CMD_JOY0, 3'd7, 32'h11));
    end
  endtask

  task automatic test_random();
    logic [7:0] cmds [6];
    logic [7:0] c;
    logic [2:0] l;
    logic [31:0] d;
    logic [39:0] got;
    int lat, rises, nd, n, exp_rx, rx0;
    bit to;
    cmds = '{CMD_BUT_SW, CMD_JOY0, CMD_JOY1, CMD_PS2_KBD, CMD_GET_CONF, CMD_STATUS32};
    exp_rx = 0;
    rx0 = rx_cnt;
    for (int i = 0; i < 8; i++) begin
      c = ($urandom_range(0, 1) == 1) ? cmds[$urandom_range(0, 5)] : 8'($urandom);
      l = 3'($urandom_range(0, 7));
      d = $urandom;
      n = (l > 3'd4) ? 4 : int'(l);
      do_frame(c, l, d, lat, rises, got, nd, to);
      n_cmp++; if (to) begin n_bad++; $display("FAIL rand%0d_timeout: got timeout want done", i); end
      n_cmp++; if (lat !== DIV*(2 + 16*(n + 1))) begin
        n_bad++; $display("FAIL rand%0d_latency: got %0d want %0d", i, lat, DIV*(2 + 16*(n + 1)));
      end
      n_cmp++; if (rises !== 8*(n + 1)) begin
        n_bad++; $display("FAIL rand%0d_rises: got %0d want %0d", i, rises, 8*(n + 1));
      end
      n_cmp++; if (got !== exp_frame(c, l, d)) begin
        n_bad++; $display("FAIL rand%0d_frame: got %h want %h", i, got, exp_frame(c, l, d));
      end
      n_cmp++; if (nd !== 1) begin n_bad++; $display("FAIL rand%0d_done_count: got %0d want 1", i, nd); end
      exp_rx += n + 1;
    end
`ifndef MIST_SPI_HOST_RX_EN
    exp_rx = 0;
`endif
    n_cmp++; if (rx_cnt - rx0 !== exp_rx) begin
      n_bad++; $display("FAIL rand_rx_pulses: got %0d want %0d", rx_cnt - rx0, exp_rx);
    end
    n_cmp++; if (mosi_idle_err !== 0) begin n_bad++; $display("FAIL mosi_idle: got %0d want 0", mosi_idle_err); end
    n_cmp++; if (ss_done_err !== 0) begin n_bad++; $display("FAIL ss_at_done: got %0d want 0", ss_done_err); end
  endtask

  task automatic test_back_to_back();
    int a0, d0, w;
    @(posedge clk_sys); #2;
    a0 = accept_cnt; d0 = done_cnt;
    min_gap = 1000; seen_frame = 1'b0;
    req_valid = 1'b1; req_len = 3'd0; req_cmd = CMD_BUT_SW; req_data = $urandom;
    repeat (600) @(posedge clk_sys);
    #2;
    req_valid = 1'b0;
    w = 0;
    while (!req_ready && w < 500) begin @(posedge clk_sys); #2; w++; end
    repeat (4) @(posedge clk_sys);
    #2;
    // Period: 72-cycle frame + 8-cycle gap + 1 accept cycle = 81; 600 cycles fit 8 accepts.
    n_cmp++; if (accept_cnt - a0 !== 8) begin n_bad++; $display("FAIL b2b_accepts: got %0d want 8", accept_cnt - a0); end
    n_cmp++; if (done_cnt - d0 !== accept_cnt - a0) begin
      n_bad++; $display("FAIL b2b_dones: got %0d want %0d", done_cnt - d0, accept_cnt - a0);
    end
    n_cmp++; if (min_gap < 8) begin n_bad++; $display("FAIL b2b_ss_gap: got %0d want >=8", min_gap); end
  endtask

  task automatic test_reset_mid_frame();
    int d0, w, lat, rises, nd;
    logic [39:0] got;
    logic [31:0] d;
    bit to;
    @(posedge clk_sys); #2;
    w = 0;
    while (!req_ready && w < 500) begin @(posedge clk_sys); #2; w++; end
    req_valid = 1'b1; req_cmd = 8'($urandom); req_len = 3'd4; req_data = $urandom;
    @(posedge clk_sys); #2;
    req_valid = 1'b0;
    d0 = done_cnt;
    @(negedge clk_sys); #1;
    w = 0;
    while (mosi_q.size() < 10 && w < 500) begin @(negedge clk_sys); #1; w++; end
    n_cmp++; if (mosi_q.size() < 10) begin n_bad++; $display("FAIL midreset_edges: got %0d want 10", mosi_q.size()); end
    #2;
    reset = 1'b1;
    #1;
    n_cmp++; if (SPI_SS_IO !== 1'b1 || SPI_SCK !== 1'b0) begin
      n_bad++; $display("FAIL midreset_async: ss=%b sck=%b want 1/0", SPI_SS_IO, SPI_SCK);
    end
    repeat (5) @(posedge clk_sys);
    #2;
    reset = 1'b0;
    repeat (20) @(posedge clk_sys);
    #2;
    n_cmp++; if (done_cnt !== d0) begin n_bad++; $display("FAIL midreset_no_done: got %0d want %0d", done_cnt - d0, 0); end
    d = $urandom;
    do_frame(CMD_BUT_SW, 3'd1, d, lat, rises, got, nd, to);
    n_cmp++; if (to || lat !== DIV*(2 + 32)) begin
      n_bad++; $display("FAIL midreset_recover_latency: got %0d want %0d", lat, DIV*(2 + 32));
    end
    n_cmp++; if (got !== exp_frame(CMD_BUT_SW, 3'd1, d)) begin
      n_bad++; $display("FAIL midreset_recover_frame: got %h want %h", got, exp_frame(CMD_BUT_SW, 3'd1, d));
    end
  endtask

`ifdef MIST_SPI_HOST_RX_EN
  task automatic test_conf_rx();
    logic [63:0] conf;
    logic [39:0] got;
    int lat, rises, nd, r0;
    bit to;
    conf = "ZigZag;;";
    miso_vec = {8'h00, conf[63:32]};
    rxb_q.delete(); rxi_q.delete();
    r0 = rx_cnt;
    do_frame(CMD_GET_CONF, 3'd4, 32'h0, lat, rises, got, nd, to);
    miso_vec = '0;
    n_cmp++; if (to || rx_cnt - r0 !== 5) begin n_bad++; $display("FAIL conf_rx_count: got %0d want 5", rx_cnt - r0); end
    for (int i = 0; i < 5 && i < rxi_q.size(); i++) begin
      n_cmp++; if (rxi_q[i] !== 3'(i)) begin n_bad++; $display("FAIL conf_rx_index%0d: got %0d want %0d", i, rxi_q[i], i); end
      if (i > 0) begin
        n_cmp++; if (rxb_q[i] !== conf[63 - 8*(i - 1) -: 8]) begin
          n_bad++; $display("FAIL conf_rx_byte%0d: got %h want %h", i, rxb_q[i], conf[63 - 8*(i - 1) -: 8]);
        end
      end
    end
  endtask
`endif

  initial begin
    repeat (3) @(posedge clk_sys);
    #2;
    reset = 1'b0;
    test_reset();
    test_status32();
    test_joystick_clamp();
    test_random();
`ifdef MIST_SPI_HOST_RX_EN
    test_conf_rx();
`endif
    test_back_to_back();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
